// File: rtl/rs_encoder.sv
// -----------------------------------------------------------------------------
// rs_encoder_pkg / rs_encoder
//
// Systematic Reed-Solomon RS(255,223) encoder over GF(2^8), byte-serial.
// Each block of RS_K message bytes is forwarded unchanged. It is followed by
// RS_PARITY_BYTES parity bytes, highest-degree parity term first.
// Field: primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02.
// Generator: g(x) = prod_{i=0..31} (x + alpha^i). It is built at elaboration
// into a constant ROM (RS_GEN).
//
// Ports
//   clk               in   1  single clock, rising edge
//   rst_n             in   1  asynchronous, active-low reset
//   s_axis_valid      in   1  input byte valid
//   s_axis_ready      out  1  encoder accepts input byte
//   s_axis_data       in   8  message byte
//   s_axis_last       in   1  marks byte RS_K-1 of a block (informational only)
//   m_axis_valid      out  1  output byte valid
//   m_axis_ready      in   1  downstream accepts output byte
//   m_axis_data       out  8  codeword byte
//   m_axis_last       out  1  high on codeword byte RS_N-1
//   m_axis_sop        out  1  high on codeword byte 0
//   m_axis_is_parity  out  1  high on codeword bytes RS_K..RS_N-1
//
// Handshake semantics (both ports): a byte moves on a rising clk edge where
// valid && ready are both high. A source that raises valid keeps valid, data
// and flags stable until that edge. The output side is one register stage.
// It can take a new byte whenever it is empty or is being drained in the same
// cycle. This allows one byte per cycle with no bubbles.
// -----------------------------------------------------------------------------

package rs_encoder_pkg;

    localparam int RS_N            = 255;
    localparam int RS_K            = 223;
    localparam int RS_PARITY_BYTES = RS_N - RS_K;

    typedef logic [7:0] rs_byte_t;

    // GF(2^8) multiply, shift-and-add with reduction by 0x11D. When one
    // operand is a constant, this collapses to a small XOR network.
    function automatic rs_byte_t gf_mul(input rs_byte_t a, input rs_byte_t b);
        rs_byte_t p;
        rs_byte_t x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    // Expand g(x) one root at a time: multiply the running polynomial by
    // (x + alpha^i). The result is packed with g_i at bits [8*i +: 8]. The
    // monic x^32 term is implied and is not stored.
    function automatic logic [8*RS_PARITY_BYTES-1:0] gen_poly();
        rs_byte_t                     g [0:RS_PARITY_BYTES];
        rs_byte_t                     root;
        logic [8*RS_PARITY_BYTES-1:0] packed_g;
        for (int j = 0; j <= RS_PARITY_BYTES; j++) begin
            g[j] = '0;
        end
        g[0] = 8'h01;
        root = 8'h01;
        for (int i = 0; i < RS_PARITY_BYTES; i++) begin
            // Descending order so each g[j-1] is still the old coefficient.
            for (int j = RS_PARITY_BYTES; j > 0; j--) begin
                g[j] = g[j-1] ^ gf_mul(g[j], root);
            end
            g[0] = gf_mul(g[0], root);
            root = gf_mul(root, 8'h02);
        end
        packed_g = '0;
        for (int j = 0; j < RS_PARITY_BYTES; j++) begin
            packed_g[8*j +: 8] = g[j];
        end
        return packed_g;
    endfunction

    localparam logic [8*RS_PARITY_BYTES-1:0] RS_GEN = gen_poly();

endpackage

module rs_encoder
    import rs_encoder_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     s_axis_valid,
    output logic     s_axis_ready,
    input  rs_byte_t s_axis_data,
    input  logic     s_axis_last,
    output logic     m_axis_valid,
    input  logic     m_axis_ready,
    output rs_byte_t m_axis_data,
    output logic     m_axis_last,
    output logic     m_axis_sop,
    output logic     m_axis_is_parity
);

    typedef enum logic {
        ST_DATA   = 1'b0,
        ST_PARITY = 1'b1
    } state_t;

    localparam logic [7:0] LP_LAST_DATA = 8'(RS_K - 1);
    localparam logic [7:0] LP_LAST_PAR  = 8'(RS_PARITY_BYTES - 1);

    // FSM state and byte counter. r_state is the observable FSM state.
    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;

    // Goes high on the first clock after reset release. It keeps s_axis_ready
    // low until then without a combinational path from rst_n.
    logic       r_active;

    // Parity LFSR. r_par[31] holds the highest-degree remainder term.
    rs_byte_t   r_par     [0:RS_PARITY_BYTES-1];
    rs_byte_t   w_par_upd [0:RS_PARITY_BYTES-1];
    rs_byte_t   w_fb;

    // Output register stage.
    logic       r_m_valid;
    rs_byte_t   r_m_data;
    logic       r_m_last;
    logic       r_m_sop;
    logic       r_m_is_parity;

    logic       w_slot_free;
    logic       w_s_ready;
    logic       w_in_fire;
    logic       w_par_fire;

    // Block boundaries come only from the internal byte counter, so
    // s_axis_last never affects framing.
    logic       w_unused_last;
    assign w_unused_last = s_axis_last;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    assign w_slot_free = !r_m_valid || m_axis_ready;
    assign w_s_ready   = r_active && (r_state == ST_DATA) && w_slot_free;
    assign w_in_fire   = s_axis_valid && w_s_ready;
    // r_active is implied here: reset forces ST_DATA, and PARITY can only be
    // reached through an accepted input byte.
    assign w_par_fire  = (r_state == ST_PARITY) && w_slot_free;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_DATA;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state. The counter advances once per byte that enters the
    // output slot. It wraps at the end of each phase.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_DATA: begin
                if (w_in_fire) begin
                    if (r_cnt == LP_LAST_DATA) begin
                        w_state_nxt = ST_PARITY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 8'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_par_fire) begin
                    if (r_cnt == LP_LAST_PAR) begin
                        w_state_nxt = ST_DATA;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_DATA;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // LFSR division step for one accepted message byte:
    //   fb = d ^ par[31]; par[i] = par[i-1] ^ fb*g_i; par[0] = fb*g_0
    // -------------------------------------------------------------------------
    always_comb begin
        w_fb         = s_axis_data ^ r_par[RS_PARITY_BYTES-1];
        w_par_upd[0] = gf_mul(w_fb, RS_GEN[7:0]);
        for (int i = 1; i < RS_PARITY_BYTES; i++) begin
            w_par_upd[i] = r_par[i-1] ^ gf_mul(w_fb, RS_GEN[8*i +: 8]);
        end
    end

    // During the parity phase the register shifts toward par[31] and fills
    // with zeros. After 32 shifts it is clear and ready for the next block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RS_PARITY_BYTES; i++) begin
                r_par[i] <= '0;
            end
        end else if (w_in_fire) begin
            for (int i = 0; i < RS_PARITY_BYTES; i++) begin
                r_par[i] <= w_par_upd[i];
            end
        end else if (w_par_fire) begin
            r_par[0] <= '0;
            for (int i = 1; i < RS_PARITY_BYTES; i++) begin
                r_par[i] <= r_par[i-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output register. Flags are registered with the byte they describe.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active      <= 1'b0;
            r_m_valid     <= 1'b0;
            r_m_data      <= '0;
            r_m_last      <= 1'b0;
            r_m_sop       <= 1'b0;
            r_m_is_parity <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (w_in_fire) begin
                r_m_valid     <= 1'b1;
                r_m_data      <= s_axis_data;
                r_m_last      <= 1'b0;
                r_m_sop       <= (r_cnt == 8'd0);
                r_m_is_parity <= 1'b0;
            end else if (w_par_fire) begin
                r_m_valid     <= 1'b1;
                r_m_data      <= r_par[RS_PARITY_BYTES-1];
                r_m_last      <= (r_cnt == LP_LAST_PAR);
                r_m_sop       <= 1'b0;
                r_m_is_parity <= 1'b1;
            end else if (m_axis_ready) begin
                // Slot drained with nothing to refill it.
                r_m_valid     <= 1'b0;
            end
        end
    end

    assign s_axis_ready     = w_s_ready;
    assign m_axis_valid     = r_m_valid;
    assign m_axis_data      = r_m_data;
    assign m_axis_last      = r_m_last;
    assign m_axis_sop       = r_m_sop;
    assign m_axis_is_parity = r_m_is_parity;

endmodule

// File: tb/tb_rs_encoder.sv
// -----------------------------------------------------------------------------
// tb_rs_encoder
//
// Self-checking bench for rs_encoder.
// Every codeword is predicted by a reference model built on GF log/antilog
// tables. Parity comes from polynomial long division by g(x). Predictions are
// pushed to exp_q when a block is queued for driving. A monitor pops and
// compares one entry per output handshake. It samples on the falling edge.
// -----------------------------------------------------------------------------
module tb_rs_encoder;

    localparam int K  = 223;
    localparam int NP = 32;
    localparam int N  = 255;

    // -------------------------------------------------------------------------
    // DUT signals
    // -------------------------------------------------------------------------
    logic       clk;
    logic       rst_n;
    logic       s_axis_valid;
    logic       s_axis_ready;
    logic [7:0] s_axis_data;
    logic       s_axis_last;
    logic       m_axis_valid;
    logic       m_axis_ready;
    logic [7:0] m_axis_data;
    logic       m_axis_last;
    logic       m_axis_sop;
    logic       m_axis_is_parity;

    rs_encoder dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis_valid     (s_axis_valid),
        .s_axis_ready     (s_axis_ready),
        .s_axis_data      (s_axis_data),
        .s_axis_last      (s_axis_last),
        .m_axis_valid     (m_axis_valid),
        .m_axis_ready     (m_axis_ready),
        .m_axis_data      (m_axis_data),
        .m_axis_last      (m_axis_last),
        .m_axis_sop       (m_axis_sop),
        .m_axis_is_parity (m_axis_is_parity)
    );

    // -------------------------------------------------------------------------
    // Bench state
    // -------------------------------------------------------------------------
    logic [10:0] exp_q[$];   // {last, is_parity, sop, data}
    logic [8:0]  in_q[$];    // {last, data}
    int          n_checks   = 0;
    int          n_errors   = 0;
    int          n_out      = 0;
    int          n_in_acc   = 0;
    int          ready_mode = 0;  // 0: always ready, 1: ~87% random, 2: held low

    logic [7:0]  gf_exp [0:255];
    int          gf_log [0:255];
    logic [7:0]  gen    [0:NP];
    logic [7:0]  msg    [0:K-1];

    // -------------------------------------------------------------------------
    // Clock and watchdog
    // -------------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    task automatic build_tables();
        logic [8:0] v;
        v = 9'h001;
        for (int i = 0; i < 255; i++) begin
            gf_exp[i]       = v[7:0];
            gf_log[v[7:0]]  = i;
            v               = v << 1;
            if (v[8]) v     = v ^ 9'h11D;
        end
        gf_exp[255] = gf_exp[0];
        gf_log[0]   = 0;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gf_exp[(gf_log[a] + gf_log[b]) % 255];
    endfunction

    task automatic build_gen();
        logic [7:0] r;
        for (int j = 0; j <= NP; j++) gen[j] = 8'h00;
        gen[0] = 8'h01;
        for (int i = 0; i < NP; i++) begin
            r = gf_exp[i];
            for (int j = NP; j > 0; j--) gen[j] = gen[j-1] ^ gmul(gen[j], r);
            gen[0] = gmul(gen[0], r);
        end
    endtask

    task automatic fill_msg(input int kind);
        for (int i = 0; i < K; i++) begin
            case (kind)
                0:       msg[i] = 8'h00;
                1:       msg[i] = (i == K-1) ? 8'h01 : 8'h00;
                default: msg[i] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    // Queue one block for driving and push its predicted codeword.
    // par_from_gen=1 takes the parity straight from the generator
    // coefficients. This is only valid for the unit message x^0.
    task automatic push_block(input bit par_from_gen);
        logic [7:0] b [0:N-1];
        logic [7:0] coef;
        for (int i = 0; i < N; i++) b[i] = (i < K) ? msg[i] : 8'h00;
        if (par_from_gen) begin
            for (int j = 0; j < NP; j++) b[K+j] = gen[NP-1-j];
        end else begin
            // Long division of m(x)*x^32 by monic g(x); b[0] is x^254.
            for (int i = 0; i < K; i++) begin
                coef = b[i];
                if (coef != 8'h00) begin
                    for (int j = 1; j <= NP; j++) b[i+j] = b[i+j] ^ gmul(coef, gen[NP-j]);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            exp_q.push_back({(i == N-1), (i >= K), (i == 0), (i < K) ? msg[i] : b[i]});
        end
        for (int i = 0; i < K; i++) in_q.push_back({(i == K-1), msg[i]});
    endtask

    // -------------------------------------------------------------------------
    // Check helper
    // -------------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Drivers: input byte stream and downstream ready
    // -------------------------------------------------------------------------
    initial begin
        logic acc;
        s_axis_valid = 1'b0;
        s_axis_data  = 8'h00;
        s_axis_last  = 1'b0;
        forever begin
            @(negedge clk);
            acc = s_axis_valid && s_axis_ready;
            @(posedge clk);
            #1;
            if (acc && in_q.size() > 0) begin
                void'(in_q.pop_front());
                n_in_acc++;
            end
            if (in_q.size() > 0) begin
                s_axis_valid                = 1'b1;
                {s_axis_last, s_axis_data}  = in_q[0];
            end else begin
                s_axis_valid = 1'b0;
                s_axis_last  = 1'b0;
                s_axis_data  = 8'h00;
            end
        end
    end

    initial begin
        m_axis_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_axis_ready = 1'b1;
                1:       m_axis_ready = ($urandom_range(0, 99) < 87);
                default: m_axis_ready = 1'b0;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard monitor
    // -------------------------------------------------------------------------
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && m_axis_valid && m_axis_ready) begin
                n_out++;
                n_checks++;
                assert (exp_q.size() > 0) else begin
                    n_errors++;
                    $error("FAIL out_extra: output %0d observed=%0h with empty queue expected=none",
                           n_out, {m_axis_last, m_axis_is_parity, m_axis_sop, m_axis_data});
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_checks++;
                    assert ({m_axis_last, m_axis_is_parity, m_axis_sop, m_axis_data} === e) else begin
                        n_errors++;
                        $error("FAIL out_byte %0d: observed={l,p,s,d}=%0h expected=%0h",
                               n_out, {m_axis_last, m_axis_is_parity, m_axis_sop, m_axis_data}, e);
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Wait helpers (bounded)
    // -------------------------------------------------------------------------
    task automatic wait_drain(input string tag);
        for (int i = 0; i < 3000 && (exp_q.size() != 0 || in_q.size() != 0); i++) @(negedge clk);
        #1;
        chk(tag, exp_q.size(), 32'd0);
        @(posedge clk);
        #2;
    endtask

    task automatic wait_out(input string tag, input int target);
        for (int i = 0; i < 2000 && n_out < target; i++) begin
            @(negedge clk);
            #1;
        end
        chk(tag, 32'(n_out >= target), 32'd1);
    endtask

    task automatic stall10(input string tag);
        ready_mode = 2;
        @(posedge clk);
        #2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk(tag, 32'({s_axis_ready, m_axis_valid, m_axis_last, m_axis_is_parity,
                          m_axis_sop, m_axis_data}),
                     32'({1'b0, 1'b1, exp_q[0]}));
        end
        ready_mode = 0;
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        int base;
        int n_hs;
        int n_low;

        build_tables();
        build_gen();

        // Reset: outputs all zero, no input acceptance.
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({s_axis_ready, m_axis_valid, m_axis_data, m_axis_last,
                                  m_axis_sop, m_axis_is_parity}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_release", 32'(s_axis_ready), 32'd1);
        @(posedge clk);
        #2;

        // All-zero message: zero data, zero parity, last on byte 254.
        fill_msg(0);
        push_block(1'b0);
        wait_drain("zero_block_drain");

        // Unit message: parity equals g31..g0.
        fill_msg(1);
        push_block(1'b1);
        wait_drain("unit_block_drain");

        // Two random blocks with random downstream backpressure.
        ready_mode = 1;
        fill_msg(2);
        push_block(1'b0);
        fill_msg(2);
        push_block(1'b0);
        wait_drain("random_blocks_drain");
        ready_mode = 0;
        @(posedge clk);
        #2;

        // Ready held low for 10 cycles mid-data and mid-parity.
        base = n_out;
        fill_msg(2);
        push_block(1'b0);
        wait_out("reach_mid_data", base + 50);
        stall10("stall_data");
        wait_out("reach_mid_parity", base + 230);
        stall10("stall_parity");
        wait_drain("stall_block_drain");

        // Reset after 100 accepted bytes; the partial block is discarded.
        base = n_in_acc;
        fill_msg(2);
        push_block(1'b0);
        for (int i = 0; i < 1000 && n_in_acc < base + 100; i++) begin
            @(posedge clk);
            #2;
        end
        chk("reach_100_in", 32'(n_in_acc >= base + 100), 32'd1);
        rst_n = 1'b0;
        in_q.delete();
        exp_q.delete();
        #1;
        chk("reset_mid_outputs", 32'({s_axis_ready, m_axis_valid, m_axis_data, m_axis_last,
                                      m_axis_sop, m_axis_is_parity}), 32'd0);
        repeat (2) @(negedge clk);
        chk("reset_mid_hold", 32'({s_axis_ready, m_axis_valid, m_axis_data, m_axis_last,
                                   m_axis_sop, m_axis_is_parity}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_mid_release", 32'(s_axis_ready), 32'd1);
        @(posedge clk);
        #2;
        fill_msg(0);
        push_block(1'b0);
        wait_drain("post_reset_block_drain");

        // Continuous flow: 510 outputs on consecutive cycles, ready low
        // for exactly 32 cycles per block.
        fill_msg(2);
        push_block(1'b0);
        fill_msg(2);
        push_block(1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_axis_valid) break;
        end
        chk("cont_start", 32'(s_axis_valid), 32'd1);
        n_hs  = 0;
        n_low = 0;
        for (int k = 0; k < 511; k++) begin
            if (k > 0) @(negedge clk);
            if (m_axis_valid && m_axis_ready) n_hs++;
            if (!s_axis_ready) n_low++;
        end
        chk("cont_out_per_cycle", 32'(n_hs), 32'd510);
        chk("cont_ready_low_cycles", 32'(n_low), 32'd64);
        wait_drain("cont_drain");

        chk("queue_empty_end", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
